// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and the microsecond-to-cycle helper
// used by the LCD row driver and its nibble transmitter.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_NIB,
    INIT_BYTE,
    SET_ADDR,
    SEND_CHAR,
    FRAME_END
  } state_t;

  typedef enum logic [2:0] {
    NIB_IDLE,
    NIB_SETUP,
    NIB_PULSE,
    NIB_HOLD,
    NIB_WAIT
  } nib_phase_t;

  localparam logic [7:0] FUNC_4BIT = 8'h28;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] ROW0_ADDR = 8'h80;
  localparam logic [7:0] ROW1_ADDR = 8'hC0;

  // 64-bit product keeps large clock rates from overflowing; only ever
  // evaluated on parameters, so the division never reaches hardware.
  function automatic int unsigned us_to_cyc(input int unsigned t_us,
                                            input int unsigned clk_hz);
    logic [63:0] prod;
    prod = (64'(t_us) * 64'(clk_hz)) / 64'd1_000_000;
    return prod[31:0];
  endfunction

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one 4-bit nibble: setup, E pulse, hold, then a 1 us gap plus the
// caller-supplied post wait. busy covers the whole sequence.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned E_PULSE_CYC = 25,
  parameter int unsigned GAP_CYC     = 100,
  parameter int unsigned WW          = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          rs,
  input  logic [3:0]    nibble,
  input  logic [WW-1:0] wait_cyc,
  output logic          busy,
  output logic          lcd_e,
  output logic          lcd_rs,
  output logic [3:0]    lcd_d
);

  localparam logic [WW-1:0] ONE        = WW'(1);
  localparam logic [WW-1:0] PULSE_LAST = WW'(E_PULSE_CYC - 1);
  localparam logic [WW-1:0] GAP_LAST   = WW'(GAP_CYC - 1);

  nib_phase_t    phase_reg, phase_next;
  logic [WW-1:0] cnt_reg, cnt_next;
  logic [WW-1:0] post_reg, post_next;
  logic          e_reg, e_next;
  logic          rs_reg, rs_next;
  logic [3:0]    d_reg, d_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_reg <= NIB_IDLE;
      cnt_reg   <= '0;
      post_reg  <= '0;
      e_reg     <= 1'b0;
      rs_reg    <= 1'b0;
      d_reg     <= 4'h0;
    end else begin
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      post_reg  <= post_next;
      e_reg     <= e_next;
      rs_reg    <= rs_next;
      d_reg     <= d_next;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    post_next  = post_reg;
    e_next     = e_reg;
    rs_next    = rs_reg;
    d_next     = d_reg;
    case (phase_reg)
      NIB_IDLE: begin
        if (start) begin
          phase_next = NIB_SETUP;
          cnt_next   = ONE;
          rs_next    = rs;
          d_next     = nibble;
          post_next  = wait_cyc;
        end
      end
      NIB_SETUP: begin
        if (cnt_reg == '0) begin
          phase_next = NIB_PULSE;
          cnt_next   = PULSE_LAST;
          e_next     = 1'b1;
        end else begin
          cnt_next = cnt_reg - ONE;
        end
      end
      NIB_PULSE: begin
        if (cnt_reg == '0) begin
          phase_next = NIB_HOLD;
          cnt_next   = ONE;
          e_next     = 1'b0;
        end else begin
          cnt_next = cnt_reg - ONE;
        end
      end
      NIB_HOLD: begin
        if (cnt_reg == '0) begin
          phase_next = NIB_WAIT;
          cnt_next   = post_reg + GAP_LAST;
        end else begin
          cnt_next = cnt_reg - ONE;
        end
      end
      NIB_WAIT: begin
        if (cnt_reg == '0) begin
          phase_next = NIB_IDLE;
        end else begin
          cnt_next = cnt_reg - ONE;
        end
      end
      default: phase_next = NIB_IDLE;
    endcase
  end

  assign busy   = (phase_reg != NIB_IDLE);
  assign lcd_e  = e_reg;
  assign lcd_rs = rs_reg;
  assign lcd_d  = d_reg;

endmodule

// File: rtl/lcd_row_driver.sv
// HD44780 4-bit driver: power-up init, then endless refresh of two 16-char
// rows snapshotted at the start of every frame.
module lcd_row_driver
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned T_PWR_US    = 20000,
  parameter int unsigned T_CMD_US    = 40,
  parameter int unsigned T_CLR_US    = 1640,
  parameter int unsigned E_PULSE_CYC = 25
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] row_A,
  input  logic [127:0] row_B,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic [3:0]   LCD_D,
  output logic         init_done,
  output logic         frame_done
);

  localparam int unsigned PWR_CYC    = us_to_cyc(T_PWR_US, CLK_HZ);
  localparam int unsigned CMD_CYC    = us_to_cyc(T_CMD_US, CLK_HZ);
  localparam int unsigned CLR_CYC    = us_to_cyc(T_CLR_US, CLK_HZ);
  localparam int unsigned GAP_CYC    = us_to_cyc(1, CLK_HZ);
  localparam int unsigned INIT0_CYC  = us_to_cyc(4100, CLK_HZ);
  localparam int unsigned INIT1_CYC  = us_to_cyc(100, CLK_HZ);
  localparam int unsigned INIT23_CYC = us_to_cyc(40, CLK_HZ);
  localparam int unsigned MAX_POST   = max_u(max_u(INIT0_CYC, INIT1_CYC),
                                             max_u(CLR_CYC, max_u(CMD_CYC, INIT23_CYC)));
  localparam int unsigned WW = $clog2(max_u(MAX_POST + GAP_CYC, E_PULSE_CYC) + 2);
  localparam int unsigned PW = $clog2(PWR_CYC + 2);

  state_t         state_reg, state_next;
  logic [PW-1:0]  pwr_cnt_reg, pwr_cnt_next;
  logic [2:0]     idx_reg, idx_next;
  logic           half_reg, half_next;
  logic [4:0]     ci_reg, ci_next;
  logic [127:0]   snap_a_reg, snap_a_next;
  logic [127:0]   snap_b_reg, snap_b_next;
  logic           init_done_reg, init_done_next;
  logic           frame_done_reg, frame_done_next;

  logic           start, nib_rs, busy, send_byte, tx_rs;
  logic [3:0]     nib_val;
  logic [WW-1:0]  nib_wait, init_nib_wait;
  logic [7:0]     tx_byte, init_byte, char_byte;
  logic [127:0]   row_sel;
  logic [6:0]     bit_lo;

  lcd_nibble_tx #(
    .E_PULSE_CYC (E_PULSE_CYC),
    .GAP_CYC     (GAP_CYC),
    .WW          (WW)
  ) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .rs       (nib_rs),
    .nibble   (nib_val),
    .wait_cyc (nib_wait),
    .busy     (busy),
    .lcd_e    (LCD_E),
    .lcd_rs   (LCD_RS),
    .lcd_d    (LCD_D)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= PWR_WAIT;
      pwr_cnt_reg    <= '0;
      idx_reg        <= '0;
      half_reg       <= 1'b0;
      ci_reg         <= '0;
      snap_a_reg     <= '0;
      snap_b_reg     <= '0;
      init_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pwr_cnt_reg    <= pwr_cnt_next;
      idx_reg        <= idx_next;
      half_reg       <= half_next;
      ci_reg         <= ci_next;
      snap_a_reg     <= snap_a_next;
      snap_b_reg     <= snap_b_next;
      init_done_reg  <= init_done_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Column c lives at bits [8*(15-c) +: 8]; 15-c is just ~c for 4 bits.
  always_comb begin
    row_sel   = ci_reg[4] ? snap_b_reg : snap_a_reg;
    bit_lo    = {~ci_reg[3:0], 3'b000};
    char_byte = row_sel[bit_lo +: 8];
    case (idx_reg[1:0])
      2'd0:    begin init_byte = FUNC_4BIT; init_nib_wait = WW'(INIT0_CYC);  end
      2'd1:    begin init_byte = ENTRY_INC; init_nib_wait = WW'(INIT1_CYC);  end
      2'd2:    begin init_byte = DISP_ON;   init_nib_wait = WW'(INIT23_CYC); end
      default: begin init_byte = CLEAR;     init_nib_wait = WW'(INIT23_CYC); end
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    pwr_cnt_next    = pwr_cnt_reg;
    idx_next        = idx_reg;
    half_next       = half_reg;
    ci_next         = ci_reg;
    snap_a_next     = snap_a_reg;
    snap_b_next     = snap_b_reg;
    init_done_next  = init_done_reg;
    frame_done_next = 1'b0;
    start           = 1'b0;
    nib_rs          = 1'b0;
    nib_val         = 4'h0;
    nib_wait        = '0;
    send_byte       = 1'b0;
    tx_byte         = 8'h00;
    tx_rs           = 1'b0;

    case (state_reg)
      PWR_WAIT: begin
        if (32'(pwr_cnt_reg) + 32'd1 >= PWR_CYC) begin
          state_next   = INIT_NIB;
          pwr_cnt_next = '0;
        end else begin
          pwr_cnt_next = pwr_cnt_reg + PW'(1);
        end
      end
      INIT_NIB: begin
        if (!busy) begin
          start    = 1'b1;
          nib_val  = (idx_reg == 3'd3) ? 4'h2 : 4'h3;
          nib_wait = init_nib_wait;
          if (idx_reg == 3'd3) begin
            idx_next   = '0;
            state_next = INIT_BYTE;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      INIT_BYTE: begin
        // idx 4 means the clear command went out; wait for its delay to end.
        if (idx_reg == 3'd4) begin
          if (!busy) begin
            init_done_next = 1'b1;
            idx_next       = '0;
            state_next     = SET_ADDR;
          end
        end else begin
          send_byte = 1'b1;
          tx_byte   = init_byte;
        end
      end
      SET_ADDR: begin
        send_byte = 1'b1;
        tx_byte   = ci_reg[4] ? ROW1_ADDR : ROW0_ADDR;
      end
      SEND_CHAR: begin
        send_byte = 1'b1;
        tx_byte   = char_byte;
        tx_rs     = 1'b1;
      end
      FRAME_END: begin
        if (!busy) begin
          frame_done_next = 1'b1;
          state_next      = SET_ADDR;
        end
      end
      default: state_next = PWR_WAIT;
    endcase

    if (send_byte && !busy) begin
      start     = 1'b1;
      nib_rs    = tx_rs;
      nib_val   = half_reg ? tx_byte[3:0] : tx_byte[7:4];
      half_next = ~half_reg;
      if (half_reg) begin
        nib_wait = (!tx_rs && (tx_byte == CLEAR || tx_byte == HOME)) ? WW'(CLR_CYC) : WW'(CMD_CYC);
      end
      if (state_reg == SET_ADDR && ci_reg == 5'd0 && !half_reg) begin
        snap_a_next = row_A;
        snap_b_next = row_B;
      end
      if (half_reg) begin
        if (state_reg == INIT_BYTE) idx_next = idx_reg + 3'd1;
        if (state_reg == SET_ADDR) state_next = SEND_CHAR;
        if (state_reg == SEND_CHAR) begin
          ci_next = ci_reg + 5'd1;
          if (ci_reg == 5'd15)      state_next = SET_ADDR;
          else if (ci_reg == 5'd31) state_next = FRAME_END;
        end
      end
    end
  end

  assign LCD_RW     = 1'b0;
  assign init_done  = init_done_reg;
  assign frame_done = frame_done_reg;

endmodule
